// File: rtl/mode_frame_sequencer.sv
// mode_frame_sequencer: collects five 4-bit samples from a valid/ready stream.
// It holds them on frame_i0..frame_i4 for the combinational mode finder, waits
// SETTLE_CYC cycles, then captures frame_mode and returns it with a frame index
// on a valid/ready result port.
// Optional build macro: MODE_FRAME_CHECK_EN adds an internal histogram
// cross-check of frame_mode and a sticky chk_err output.
module mode_frame_sequencer #(
  parameter int SETTLE_CYC = 2,
  parameter int FCNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_data,
  output logic [3:0]        frame_i0,
  output logic [3:0]        frame_i1,
  output logic [3:0]        frame_i2,
  output logic [3:0]        frame_i3,
  output logic [3:0]        frame_i4,
  input  logic [3:0]        frame_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_mode,
  output logic [FCNT_W-1:0] out_fidx
`ifdef MODE_FRAME_CHECK_EN
  ,
  output logic              chk_err
`endif
);

  generate
    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
      $error("mode_frame_sequencer: SETTLE_CYC must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {FILL, SETTLE, HOLD} state_t;

  state_t              state, state_nxt;
  logic [2:0]          cnt;
  logic [3:0]          settle;
  logic [4:0][3:0]     slot;
  logic [FCNT_W-1:0]   fcnt;
  logic                accept;
  logic                capture;

  assign accept   = in_valid & in_ready;
  assign frame_i0 = slot[0];
  assign frame_i1 = slot[1];
  assign frame_i2 = slot[2];
  assign frame_i3 = slot[3];
  assign frame_i4 = slot[4];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  // Next-state, input ready and capture strobe
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    capture   = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (accept && cnt == 3'd4) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (settle == 4'd0) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // out_valid is always high in HOLD, so out_ready alone completes it
        if (out_ready) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Frame assembly and settle countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 3'd0;
      settle <= 4'd0;
      slot   <= '0;
    end else if (accept) begin
      slot[cnt] <= in_data;
      if (cnt == 3'd4) begin
        cnt    <= 3'd0;
        settle <= 4'(SETTLE_CYC - 1);
      end else begin
        cnt <= cnt + 3'd1;
      end
    end else if (state == SETTLE && settle != 4'd0) begin
      settle <= settle - 4'd1;
    end
  end

  // Result capture and output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mode  <= 4'd0;
      out_fidx  <= '0;
      fcnt      <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_mode  <= frame_mode;
      out_fidx  <= fcnt;
      fcnt      <= fcnt + 1'b1;
    end else if (state == HOLD && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MODE_FRAME_CHECK_EN
  logic [15:0][2:0] hist;
  logic [3:0]       exp_mode;
  logic [2:0]       best_c;

  // Per-frame value histogram; five accepts never overflow a 3-bit count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              hist <= '0;
    else if (state == HOLD && state_nxt == FILL) hist <= '0;
    else if (accept)                         hist[in_data] <= hist[in_data] + 3'd1;
  end

  // Highest count wins; scanning upward with >= resolves ties to the larger value
  always_comb begin
    exp_mode = 4'd0;
    best_c   = 3'd0;
    for (int v = 0; v < 16; v++) begin
      if (hist[v] >= best_c) begin
        best_c   = hist[v];
        exp_mode = 4'(v);
      end
    end
  end

  // Sticky disagreement flag, evaluated at the capture cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  chk_err <= 1'b0;
    else if (capture && exp_mode != frame_mode)  chk_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mode_frame_sequencer.sv
// Self-checking bench for mode_frame_sequencer: behavioural mode finder plus
// count-based reference model, randomized frames and directed scenarios.
module tb_mode_frame_sequencer;
  localparam int SETTLE = 2;
  localparam int FW     = 8;

  typedef logic [4:0][3:0] frame_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_data = 4'd0;
  logic [3:0]    f0, f1, f2, f3, f4;
  logic [3:0]    frame_mode;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    out_mode;
  logic [FW-1:0] out_fidx;
`ifdef MODE_FRAME_CHECK_EN
  logic          chk_err;
  bit            force_bad = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mode_frame_sequencer #(.SETTLE_CYC(SETTLE), .FCNT_W(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .frame_i0(f0), .frame_i1(f1), .frame_i2(f2), .frame_i3(f3), .frame_i4(f4),
    .frame_mode(frame_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .out_fidx(out_fidx)
`ifdef MODE_FRAME_CHECK_EN
    , .chk_err(chk_err)
`endif
  );

  // Reference mode: count occurrences, pick the highest count, largest value on ties
  function automatic logic [3:0] ref_mode(input frame_t fr);
    int c[16];
    int best;
    logic [3:0] bv;
    foreach (c[i]) c[i] = 0;
    for (int k = 0; k < 5; k++) c[fr[k]]++;
    best = -1;
    bv   = 4'd0;
    for (int v = 15; v >= 0; v--)
      if (c[v] > best) begin best = c[v]; bv = 4'(v); end
    return bv;
  endfunction

  function automatic frame_t mk(input int a, b, c, d, e);
    frame_t r;
    r[0] = 4'(a); r[1] = 4'(b); r[2] = 4'(c); r[3] = 4'(d); r[4] = 4'(e);
    return r;
  endfunction

  function automatic frame_t rnd_frame(input bit narrow);
    frame_t r;
    for (int k = 0; k < 5; k++)
      r[k] = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    return r;
  endfunction

  // Behavioural mode finder driving the DUT
  always_comb begin
    frame_mode = ref_mode({f4, f3, f2, f1, f0});
`ifdef MODE_FRAME_CHECK_EN
    if (force_bad) frame_mode = 4'd4;
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Present one sample and hold it until it is accepted (bounded)
  task automatic send(input logic [3:0] v, output bit ok);
    int n = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    ok = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_frame(input frame_t s, input bit gaps, output bit ok);
    bit o;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      send(s[k], o);
      ok &= o;
    end
  endtask

  // Count edges from the 5th accept until out_valid is seen (bounded)
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 50) begin @(posedge clk); #1; edges++; end
  endtask

  task automatic run_frame(input frame_t s, input bit gaps, output bit ok, output int edges);
    push_frame(s, gaps, ok);
    wait_valid(edges);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_hs got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
    end
    checks++;
    if ({f4, f3, f2, f1, f0, out_mode, out_fidx} !== '0) begin
      failures++; $display("FAIL reset_data got frame=%h mode=%0d fidx=%0d exp all 0", {f4, f3, f2, f1, f0}, out_mode, out_fidx);
    end
  endtask

  task automatic test_basic();
    frame_t s = mk(3, 7, 3, 9, 3);
    bit ok; int e;
    do_reset();
    out_ready = 1'b1;
    push_frame(s, 1'b0, ok);
    checks++;
    if (!ok || {f4, f3, f2, f1, f0} !== s) begin
      failures++; $display("FAIL basic_frame got ok=%b frame=%h exp %h", ok, {f4, f3, f2, f1, f0}, s);
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_settle got ready=%b valid=%b exp 0 0", in_ready, out_valid);
    end
    wait_valid(e);
    checks++;
    if (e != SETTLE || out_mode !== 4'd3 || out_fidx !== '0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL basic_result got edges=%0d mode=%0d fidx=%0d ready=%b exp %0d 3 0 0", e, out_mode, out_fidx, in_ready, SETTLE);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL basic_release got valid=%b ready=%b exp 0 1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_two_frames();
    frame_t s[2];
    bit ok; int e;
    s[0] = mk(1, 2, 3, 4, 5);
    s[1] = mk(6, 6, 2, 2, 9);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run_frame(s[i], 1'b0, ok, e);
      checks++;
      if (!ok || e != SETTLE || out_mode !== ref_mode(s[i]) || out_fidx !== FW'(i)) begin
        failures++; $display("FAIL two_frames[%0d] got ok=%b edges=%0d mode=%0d fidx=%0d exp mode=%0d fidx=%0d", i, ok, e, out_mode, out_fidx, ref_mode(s[i]), i);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        failures++; $display("FAIL two_frames_bubble[%0d] got ready=%b exp 0", i, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    frame_t s = rnd_frame(1'b0);
    frame_t n;
    frame_t held;
    logic [3:0] m;
    bit ok, o; int e;
    do_reset();
    run_frame(s, 1'b0, ok, e);
    m    = out_mode;
    held = {f4, f3, f2, f1, f0};
    checks++;
    if (!ok || m !== ref_mode(s) || out_fidx !== '0) begin
      failures++; $display("FAIL bp_result got mode=%0d fidx=%0d exp %0d 0", m, out_fidx, ref_mode(s));
    end
    n = rnd_frame(1'b0);
    in_valid = 1'b1;
    in_data  = n[0];
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_mode !== m || {f4, f3, f2, f1, f0} !== held) begin
        failures++; $display("FAIL bp_hold[%0d] got valid=%b ready=%b mode=%0d frame=%h exp 1 0 %0d %h", c, out_valid, in_ready, out_mode, {f4, f3, f2, f1, f0}, m, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {f4, f3, f2, f1, f0} !== held) begin
      failures++; $display("FAIL bp_release got valid=%b ready=%b frame=%h exp 0 1 %h", out_valid, in_ready, {f4, f3, f2, f1, f0}, held);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (f0 !== n[0]) begin
      failures++; $display("FAIL bp_next_first got %0d exp %0d", f0, n[0]);
    end
    for (int k = 1; k < 5; k++) send(n[k], o);
    wait_valid(e);
    checks++;
    if (e != SETTLE || out_mode !== ref_mode(n) || out_fidx !== FW'(1)) begin
      failures++; $display("FAIL bp_next_result got edges=%0d mode=%0d fidx=%0d exp %0d %0d 1", e, out_mode, out_fidx, SETTLE, ref_mode(n));
    end
    consume();
  endtask

  task automatic test_reset_midframe();
    bit ok, o; int e;
    do_reset();
    run_frame(mk(9, 9, 9, 1, 1), 1'b0, ok, e);
    consume();
    send(4'd5, o); send(4'd6, o); send(4'd7, o);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({f4, f3, f2, f1, f0, out_mode, out_fidx} !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL midreset_clear got frame=%h mode=%0d fidx=%0d valid=%b ready=%b exp zeros ready=1", {f4, f3, f2, f1, f0}, out_mode, out_fidx, out_valid, in_ready);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    run_frame(mk(15, 15, 0, 0, 0), 1'b0, ok, e);
    checks++;
    if (!ok || e != SETTLE || out_mode !== 4'd0 || out_fidx !== '0) begin
      failures++; $display("FAIL midreset_frame got edges=%0d mode=%0d fidx=%0d exp %0d 0 0", e, out_mode, out_fidx, SETTLE);
    end
    consume();
  endtask

  task automatic test_wrap();
    frame_t s;
    bit ok; int e;
    do_reset();
    for (int i = 0; i < 257; i++) begin
      s = rnd_frame(i[0]);
      run_frame(s, 1'b1, ok, e);
      checks++;
      if (!ok || e != SETTLE || out_mode !== ref_mode(s) || out_fidx !== FW'(i)) begin
        failures++; $display("FAIL wrap[%0d] got edges=%0d mode=%0d fidx=%0d exp %0d %0d %0d", i, e, out_mode, out_fidx, SETTLE, ref_mode(s), FW'(i));
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
        failures++; $display("FAIL wrap_stall[%0d] got valid=%b exp 1", i, out_valid);
      end
      consume();
    end
  endtask

`ifdef MODE_FRAME_CHECK_EN
  task automatic test_check();
    bit ok; int e;
    do_reset();
    run_frame(mk(8, 8, 8, 1, 2), 1'b0, ok, e);
    checks++;
    if (chk_err !== 1'b0 || out_mode !== 4'd8) begin
      failures++; $display("FAIL chk_clean got err=%b mode=%0d exp 0 8", chk_err, out_mode);
    end
    consume();
    force_bad = 1'b1;
    run_frame(mk(8, 8, 8, 1, 2), 1'b0, ok, e);
    checks++;
    if (chk_err !== 1'b1 || out_mode !== 4'd4) begin
      failures++; $display("FAIL chk_detect got err=%b mode=%0d exp 1 4", chk_err, out_mode);
    end
    consume();
    force_bad = 1'b0;
    run_frame(mk(1, 1, 3, 3, 0), 1'b0, ok, e);
    checks++;
    if (chk_err !== 1'b1 || out_mode !== 4'd3) begin
      failures++; $display("FAIL chk_sticky got err=%b mode=%0d exp 1 3", chk_err, out_mode);
    end
    consume();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_two_frames();
    test_backpressure();
    test_reset_midframe();
    test_wrap();
`ifdef MODE_FRAME_CHECK_EN
    test_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
